// File: rtl/aldffe_checker_if.sv
// aldffe_checker_if: stimulus, observed DUT output and run results shared by a checker and its driver
interface aldffe_checker_if #(parameter int WIDTH = 4);
  logic start, en, aload;
  logic [WIDTH-1:0] d, ad, q_dut;
  logic busy, done, pass;
  logic [7:0] err_count, check_count, first_err_idx;
  logic [WIDTH-1:0] first_err_exp, first_err_got;
  modport master (
    output start, en, aload, d, ad, q_dut,
    input busy, done, pass, err_count, check_count, first_err_idx, first_err_exp, first_err_got
  );
  modport slave (
    input start, en, aload, d, ad, q_dut,
    output busy, done, pass, err_count, check_count, first_err_idx, first_err_exp, first_err_got
  );
endinterface

// File: rtl/aldffe_checker.sv
// aldffe_checker: models a load/enable flip-flop and scores a DUT's q against it over N_CHECKS compares
module aldffe_checker #(
  parameter int WIDTH = 4,
  parameter int N_CHECKS = 16
) (
  input logic clk,
  input logic rst,
  aldffe_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] exp, first_err_exp, first_err_got;
  logic [7:0] err_count, check_count, first_err_idx;
  logic exp_valid, launch, cmp, mismatch, last;
  assign launch = state != RUN && bus.start;
  assign cmp = state == RUN && exp_valid;
  assign mismatch = cmp && bus.q_dut != exp;
  assign last = cmp && check_count == 8'(N_CHECKS - 1);
  always_comb state_nxt = launch ? RUN : last ? DONE : state;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  // compare uses exp from the previous edge; the load below only affects the next cycle
  always_ff @(posedge clk)
    if (rst || launch) begin
      exp <= '0;
      exp_valid <= 1'b0;
      err_count <= '0;
      check_count <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (state == RUN) begin
      if (bus.aload || bus.en) begin
        exp <= bus.aload ? bus.ad : bus.d;
        exp_valid <= 1'b1;
      end
      if (cmp) check_count <= check_count + 8'd1;
      if (mismatch) begin
        if (err_count != 8'hff) err_count <= err_count + 8'd1;
        if (err_count == 8'd0) begin
          first_err_idx <= check_count;
          first_err_exp <= exp;
          first_err_got <= bus.q_dut;
        end
      end
    end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.pass = state == DONE && err_count == 8'd0;
  assign bus.err_count = err_count;
  assign bus.check_count = check_count;
  assign bus.first_err_idx = first_err_idx;
  assign bus.first_err_exp = first_err_exp;
  assign bus.first_err_got = first_err_got;
endmodule

// File: doc/aldffe_checker.md
ALDFFE_CHECKER -- requirements
Module: aldffe_checker

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the checked data path.
REQ-002 Parameter N_CHECKS, default 16: number of cycles checked per run, range 1..255.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 start  input  1: begin a check run.
REQ-006 en  input  1: DUT enable as driven by the stimulus.
REQ-007 aload  input  1: DUT load as driven by the stimulus.
REQ-008 d  input  WIDTH: DUT data input.
REQ-009 ad  input  WIDTH: DUT load data.
REQ-010 q_dut  input  WIDTH: DUT output under check.
REQ-011 busy  output  1: run in progress.
REQ-012 done  output  1: run finished; results valid.
REQ-013 pass  output  1: run finished with zero mismatches.
REQ-014 err_count  output  8: mismatch count, saturating at 255.
REQ-015 check_count  output  8: compared cycles in the current or last run.
REQ-016 first_err_idx  output  8: check_count value at the first mismatch.
REQ-017 first_err_exp  output  WIDTH: expected value at the first mismatch.
REQ-018 first_err_got  output  WIDTH: q_dut value at the first mismatch.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 IDLE to RUN on a cycle with start=1; on that edge clear err_count, check_count, first_err_*, and exp_valid.
REQ-021 RUN model: at each edge, exp <= ad if aload=1, else d if en=1, else exp unchanged; aload has priority over en.
REQ-022 RUN: exp_valid SHALL be set at the first edge with aload=1 or en=1 and remain set until the next run starts.
REQ-023 RUN compare: each cycle with exp_valid=1, compare q_dut against exp (the value registered at the previous edge), then increment check_count.
REQ-024 RUN with exp_valid=0: no compare; check_count unchanged.
REQ-025 Mismatch (q_dut != exp, any bit): increment err_count, saturating at 255.
REQ-026 On the first mismatch of a run only: capture first_err_idx=check_count (pre-increment), first_err_exp=exp and first_err_got=q_dut.
REQ-027 RUN to DONE on the edge at which check_count reaches N_CHECKS; the compare on that final cycle is included.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 DONE holds all results; DONE to RUN on start=1, with the same clearing as REQ-020.
REQ-030 busy=1 exactly in RUN; done=1 exactly in DONE; pass=done AND (err_count==0); all outputs registered or decoded from state only.
REQ-031 Equal aload and en activity in the same cycle: aload wins (REQ-021); the compare in that cycle still uses the previous exp.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and zero busy, done, pass, err_count, check_count, first_err_idx, first_err_exp, first_err_got, exp and exp_valid, overriding start.
REQ-033 rst asserted mid-RUN SHALL discard the run; no partial result is presented on done.

Verification
REQ-034 Reset, then start with aload=1 and ad=1010 for 1 cycle, then en=0 and q_dut tracking the model for 16 compares -> done=1, pass=1, err_count=0, check_count=16.
REQ-035 As REQ-034 but force q_dut=0000 on compare index 3 only -> err_count=1, first_err_idx=3, first_err_exp=1010, first_err_got=0000, pass=0.
REQ-036 aload=1 and en=1 in the same cycle with ad=1010 and d=0101 -> next-cycle expected value 1010.
REQ-037 start with en=0 and aload=0 for 5 cycles -> check_count stays 0, busy=1, err_count=0.
REQ-038 rst pulsed at compare 8 of a failing run -> IDLE, all outputs 0; a new start produces a clean run.
REQ-039 N_CHECKS=255 with q_dut always wrong -> err_count=255 (saturated), check_count=255, done=1.
